// File: rtl/fp_special_resolver_pkg.sv
// -----------------------------------------------------------------------------
// fp_pkg
// Shared definitions for the FP special-operand resolver:
//   - binary32 / binary64 field widths (picked by the IS_DOUBLE parameter)
//   - op_mode encodings
//   - bit positions inside the 5-bit {NV, DZ, OF, UF, NX} flag vector
//   - the per-operand class vector produced by fp_classify
// -----------------------------------------------------------------------------
package fp_pkg;

    localparam int SP_EXP_W  = 8;
    localparam int SP_MANT_W = 23;
    localparam int DP_EXP_W  = 11;
    localparam int DP_MANT_W = 52;

    typedef enum logic [1:0] {
        FP_MUL = 2'b00,
        FP_DIV = 2'b01,
        FP_ADD = 2'b10,
        FP_SUB = 2'b11
    } fp_op_e;

    localparam int FLAG_NV = 4;
    localparam int FLAG_DZ = 3;
    localparam int FLAG_OF = 2;
    localparam int FLAG_UF = 1;
    localparam int FLAG_NX = 0;

    // finite covers zero, subnormal and normal encodings (exponent not all ones)
    typedef struct packed {
        logic nan;
        logic snan;
        logic inf;
        logic zero;
        logic finite;
    } fp_class_t;

endpackage

// File: rtl/fp_special_resolver_if.sv
// -----------------------------------------------------------------------------
// fp_special_resolver_if
// Bundles the operand-side and result-side handshakes plus the sticky flag
// controls of the special-operand resolver.
//   master : upstream producer / downstream consumer (drives operands,
//            out_ready, flags_clr)
//   slave  : the resolver itself
// -----------------------------------------------------------------------------
interface fp_special_resolver_if #(
    parameter int TOTAL_WIDTH = 32
);
    logic                   in_valid;
    logic                   in_ready;
    logic [TOTAL_WIDTH-1:0] op_a;
    logic [TOTAL_WIDTH-1:0] op_b;
    logic [1:0]             op_mode;
    logic                   out_valid;
    logic                   out_ready;
    logic                   out_special;
    logic [TOTAL_WIDTH-1:0] out_result;
    logic [4:0]             out_flags;
    logic [4:0]             sticky_flags;
    logic                   flags_clr;

    modport master (
        output in_valid, op_a, op_b, op_mode, out_ready, flags_clr,
        input  in_ready, out_valid, out_special, out_result, out_flags, sticky_flags
    );

    modport slave (
        input  in_valid, op_a, op_b, op_mode, out_ready, flags_clr,
        output in_ready, out_valid, out_special, out_result, out_flags, sticky_flags
    );
endinterface

// File: rtl/fp_special_resolver_classify.sv
// -----------------------------------------------------------------------------
// fp_classify
// Combinational class decode of one IEEE-754 operand (sign not needed).
//   i_op    : {exponent, fraction} of the operand
//   o_class : {nan, snan, inf, zero, finite}
// With DAZ != 0 every exponent-0 encoding (subnormals included) is a zero.
// -----------------------------------------------------------------------------
module fp_classify
    import fp_pkg::*;
#(
    parameter int EXP_WIDTH  = 8,
    parameter int MANT_WIDTH = 23,
    parameter int DAZ        = 0
) (
    input  logic [EXP_WIDTH+MANT_WIDTH-1:0] i_op,
    output fp_class_t                       o_class
);
    logic [EXP_WIDTH-1:0]  w_exp;
    logic [MANT_WIDTH-1:0] w_frac;
    logic                  w_expOnes;
    logic                  w_expZero;
    logic                  w_fracZero;

    assign w_exp      = i_op[EXP_WIDTH+MANT_WIDTH-1:MANT_WIDTH];
    assign w_frac     = i_op[MANT_WIDTH-1:0];
    assign w_expOnes  = &w_exp;
    assign w_expZero  = ~|w_exp;
    assign w_fracZero = ~|w_frac;

    // A signalling NaN is a NaN whose quiet bit (fraction MSB) is clear
    always_comb begin
        o_class.nan    = w_expOnes & ~w_fracZero;
        o_class.snan   = w_expOnes & ~w_fracZero & ~w_frac[MANT_WIDTH-1];
        o_class.inf    = w_expOnes & w_fracZero;
        o_class.zero   = w_expZero & (w_fracZero | (DAZ != 0));
        o_class.finite = ~w_expOnes;
    end
endmodule

// File: rtl/fp_special_resolver.sv
// -----------------------------------------------------------------------------
// fp_special_resolver
// Two-stage pipeline deciding whether an FP MUL/DIV/ADD/SUB result is fixed by
// special operands (NaN, Inf, zero, zero-addend passthrough).
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : fp_special_resolver_if.slave
//                in_valid/in_ready/op_a/op_b/op_mode   operand handshake
//                out_valid/out_ready/out_special/out_result/out_flags
//                sticky_flags/flags_clr                accumulated flags
// S1 registers the operand classes, effective signs, mode and raw operands.
// S2 registers the resolved result and flags.
// -----------------------------------------------------------------------------
module fp_special_resolver
    import fp_pkg::*;
#(
    parameter int IS_DOUBLE      = 0,
    parameter int EXP_WIDTH      = IS_DOUBLE ? DP_EXP_W : SP_EXP_W,
    parameter int MANT_WIDTH     = IS_DOUBLE ? DP_MANT_W : SP_MANT_W,
    parameter int TOTAL_WIDTH    = EXP_WIDTH + MANT_WIDTH + 1,
    parameter int CANON_NAN_SIGN = 1,
    parameter int DAZ            = 0
) (
    input logic                  clk,
    input logic                  rst_n,
    fp_special_resolver_if.slave bus
);
    localparam logic CANON_SIGN = (CANON_NAN_SIGN != 0);
    localparam logic [TOTAL_WIDTH-1:0] QUIET_BIT =
        {{(TOTAL_WIDTH-MANT_WIDTH){1'b0}}, 1'b1, {(MANT_WIDTH-1){1'b0}}};
    localparam logic [TOTAL_WIDTH-1:0] CANON_NAN =
        {CANON_SIGN, {EXP_WIDTH{1'b1}}, 1'b1, {(MANT_WIDTH-1){1'b0}}};

    logic                   w_s2Load;
    logic                   w_s1Load;
    fp_class_t              w_clsA;
    fp_class_t              w_clsB;
    logic                   w_signB;

    logic                   r_s1V;
    fp_class_t              r_s1ClsA;
    fp_class_t              r_s1ClsB;
    logic                   r_s1SignA;
    logic                   r_s1SignB;
    logic [1:0]             r_s1Mode;
    logic [TOTAL_WIDTH-1:0] r_s1OpA;
    logic [TOTAL_WIDTH-1:0] r_s1OpB;

    logic                   w_special;
    logic [TOTAL_WIDTH-1:0] w_result;
    logic [4:0]             w_flags;
    logic                   w_invalid;
    logic                   w_signX;

    logic                   r_s2V;
    logic                   r_special;
    logic [TOTAL_WIDTH-1:0] r_result;
    logic [4:0]             r_flags;
    logic [4:0]             r_sticky;

    assign w_s2Load     = ~r_s2V | bus.out_ready;
    assign w_s1Load     = ~r_s1V | w_s2Load;
    assign bus.in_ready = w_s1Load;

    // SUB is resolved as ADD with b's sign inverted
    assign w_signB = bus.op_b[TOTAL_WIDTH-1] ^ (bus.op_mode == FP_SUB);

    fp_classify #(.EXP_WIDTH(EXP_WIDTH), .MANT_WIDTH(MANT_WIDTH), .DAZ(DAZ)) u_classA (
        .i_op    (bus.op_a[TOTAL_WIDTH-2:0]),
        .o_class (w_clsA)
    );

    fp_classify #(.EXP_WIDTH(EXP_WIDTH), .MANT_WIDTH(MANT_WIDTH), .DAZ(DAZ)) u_classB (
        .i_op    (bus.op_b[TOTAL_WIDTH-2:0]),
        .o_class (w_clsB)
    );

    // Stage 1: capture the classified pair whenever the stage may advance
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1V     <= 1'b0;
            r_s1ClsA  <= '0;
            r_s1ClsB  <= '0;
            r_s1SignA <= 1'b0;
            r_s1SignB <= 1'b0;
            r_s1Mode  <= '0;
            r_s1OpA   <= '0;
            r_s1OpB   <= '0;
        end else if (w_s1Load) begin
            r_s1V <= bus.in_valid;
            if (bus.in_valid) begin
                r_s1ClsA  <= w_clsA;
                r_s1ClsB  <= w_clsB;
                r_s1SignA <= bus.op_a[TOTAL_WIDTH-1];
                r_s1SignB <= w_signB;
                r_s1Mode  <= bus.op_mode;
                r_s1OpA   <= bus.op_a;
                r_s1OpB   <= bus.op_b;
            end
        end
    end

    assign w_signX = r_s1SignA ^ r_s1SignB;

    // Invalid operations that produce the canonical NaN
    always_comb begin
        w_invalid = 1'b0;
        case (r_s1Mode)
            FP_MUL:  w_invalid = (r_s1ClsA.inf & r_s1ClsB.zero) | (r_s1ClsA.zero & r_s1ClsB.inf);
            FP_DIV:  w_invalid = (r_s1ClsA.zero & r_s1ClsB.zero) | (r_s1ClsA.inf & r_s1ClsB.inf);
            default: w_invalid = r_s1ClsA.inf & r_s1ClsB.inf & (r_s1SignA != r_s1SignB);
        endcase
    end

    // Priority resolution: NaN propagation, invalid, MUL/DIV, ADD/SUB, else datapath
    always_comb begin
        w_special = 1'b0;
        w_result  = '0;
        w_flags   = '0;
        if (r_s1ClsA.nan | r_s1ClsB.nan) begin
            w_special        = 1'b1;
            w_result         = (r_s1ClsA.nan ? r_s1OpA : r_s1OpB) | QUIET_BIT;
            w_flags[FLAG_NV] = r_s1ClsA.snan | r_s1ClsB.snan;
        end else if (w_invalid) begin
            w_special        = 1'b1;
            w_result         = CANON_NAN;
            w_flags[FLAG_NV] = 1'b1;
        end else begin
            case (r_s1Mode)
                FP_MUL: begin
                    if (r_s1ClsA.inf | r_s1ClsB.inf) begin
                        w_special = 1'b1;
                        w_result  = {w_signX, {EXP_WIDTH{1'b1}}, {MANT_WIDTH{1'b0}}};
                    end else if (r_s1ClsA.zero | r_s1ClsB.zero) begin
                        w_special = 1'b1;
                        w_result  = {w_signX, {(TOTAL_WIDTH-1){1'b0}}};
                    end
                end
                FP_DIV: begin
                    if (r_s1ClsA.inf) begin
                        w_special = 1'b1;
                        w_result  = {w_signX, {EXP_WIDTH{1'b1}}, {MANT_WIDTH{1'b0}}};
                    end else if (r_s1ClsA.finite & ~r_s1ClsA.zero & r_s1ClsB.zero) begin
                        w_special        = 1'b1;
                        w_result         = {w_signX, {EXP_WIDTH{1'b1}}, {MANT_WIDTH{1'b0}}};
                        w_flags[FLAG_DZ] = 1'b1;
                    end else if (r_s1ClsA.zero | r_s1ClsB.inf) begin
                        w_special = 1'b1;
                        w_result  = {w_signX, {(TOTAL_WIDTH-1){1'b0}}};
                    end
                end
                default: begin
                    if (r_s1ClsA.inf) begin
                        w_special = 1'b1;
                        w_result  = {r_s1SignA, {EXP_WIDTH{1'b1}}, {MANT_WIDTH{1'b0}}};
                    end else if (r_s1ClsB.inf) begin
                        w_special = 1'b1;
                        w_result  = {r_s1SignB, {EXP_WIDTH{1'b1}}, {MANT_WIDTH{1'b0}}};
                    end else if (r_s1ClsA.zero & r_s1ClsB.zero) begin
                        w_special = 1'b1;
                        w_result  = {r_s1SignA & r_s1SignB, {(TOTAL_WIDTH-1){1'b0}}};
                    end else if (r_s1ClsA.zero) begin
                        w_special = 1'b1;
                        w_result  = {r_s1SignB, r_s1OpB[TOTAL_WIDTH-2:0]};
                    end else if (r_s1ClsB.zero) begin
                        w_special = 1'b1;
                        w_result  = r_s1OpA;
                    end
                end
            endcase
        end
    end

    // Stage 2: output register, held while the consumer stalls
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2V     <= 1'b0;
            r_special <= 1'b0;
            r_result  <= '0;
            r_flags   <= '0;
        end else if (w_s2Load) begin
            r_s2V <= r_s1V;
            if (r_s1V) begin
                r_special <= w_special;
                r_result  <= w_result;
                r_flags   <= w_flags;
            end
        end
    end

    // Sticky flags accumulate on output handshakes; a clear wins over an update
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sticky <= '0;
        end else if (bus.flags_clr) begin
            r_sticky <= '0;
        end else if (r_s2V & bus.out_ready) begin
            r_sticky <= r_sticky | r_flags;
        end
    end

    assign bus.out_valid    = r_s2V;
    assign bus.out_special  = r_special;
    assign bus.out_result   = r_result;
    assign bus.out_flags    = r_flags;
    assign bus.sticky_flags = r_sticky;
endmodule

// File: tb/tb_fp_special_resolver.sv
// -----------------------------------------------------------------------------
// tb_fp_special_resolver
// Directed-vector bench for fp_special_resolver in binary32 mode.
// -----------------------------------------------------------------------------
module tb_fp_special_resolver;

    localparam logic [1:0] MUL = 2'b00;
    localparam logic [1:0] DIV = 2'b01;
    localparam logic [1:0] ADD = 2'b10;
    localparam logic [1:0] SUB = 2'b11;

    typedef struct packed {
        logic [1:0]  mode;
        logic [31:0] a;
        logic [31:0] b;
        logic        sp;
        logic [31:0] r;
        logic [4:0]  f;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    fp_special_resolver_if #(.TOTAL_WIDTH(32)) bus ();

    fp_special_resolver #(.IS_DOUBLE(0)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Drives one pair, waits for its result; called #1 after a rising edge
    task automatic sendPair(input logic [31:0] a, input logic [31:0] b, input logic [1:0] mode,
                            input logic rdy, output logic special, output logic [31:0] result,
                            output logic [4:0] flags, output int lat);
        int waitCnt;
        bus.op_a      = a;
        bus.op_b      = b;
        bus.op_mode   = mode;
        bus.out_ready = rdy;
        bus.in_valid  = 1'b1;
        waitCnt       = 0;
        @(negedge clk);
        while (!bus.in_ready && waitCnt < 20) begin
            @(negedge clk);
            waitCnt++;
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        lat = 1;
        while (!bus.out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        special = bus.out_special;
        result  = bus.out_result;
        flags   = bus.out_flags;
    endtask

    task automatic test_reset();
        checks++;
        if (bus.out_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_out_valid got=%b want=0", bus.out_valid);
        end
        checks++;
        if ({bus.out_special, bus.out_result, bus.out_flags} !== 38'd0) begin
            failures++;
            $display("[TB] FAIL reset_outputs got=%b/%h/%b want=0/00000000/00000",
                     bus.out_special, bus.out_result, bus.out_flags);
        end
        checks++;
        if (bus.sticky_flags !== 5'b00000) begin
            failures++;
            $display("[TB] FAIL reset_sticky got=%b want=00000", bus.sticky_flags);
        end
        checks++;
        if (bus.in_ready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL reset_in_ready got=%b want=1", bus.in_ready);
        end
    endtask

    task automatic test_latency();
        logic        sp;
        logic [31:0] r;
        logic [4:0]  f;
        int          lat;
        sendPair(32'h7F800000, 32'h00000000, MUL, 1'b1, sp, r, f, lat);
        checks++;
        if (lat !== 2) begin
            failures++;
            $display("[TB] FAIL latency got=%0d want=2", lat);
        end
        checks++;
        if ({sp, r, f} !== {1'b1, 32'hFFC00000, 5'b10000}) begin
            failures++;
            $display("[TB] FAIL latency_result got=%b/%h/%b want=1/ffc00000/10000", sp, r, f);
        end
    endtask

    task automatic test_special_cases();
        vec_t        v [17];
        logic        sp;
        logic [31:0] r;
        logic [4:0]  f;
        int          lat;
        v = '{
            '{MUL, 32'h7F800001, 32'h3F800000, 1'b1, 32'h7FC00001, 5'b10000},
            '{MUL, 32'h3F800000, 32'hFFC00005, 1'b1, 32'hFFC00005, 5'b00000},
            '{DIV, 32'h3F800000, 32'h80000000, 1'b1, 32'hFF800000, 5'b01000},
            '{DIV, 32'h00000000, 32'h00000000, 1'b1, 32'hFFC00000, 5'b10000},
            '{SUB, 32'h7F800000, 32'h7F800000, 1'b1, 32'hFFC00000, 5'b10000},
            '{ADD, 32'h80000000, 32'h00000000, 1'b1, 32'h00000000, 5'b00000},
            '{SUB, 32'h40000000, 32'h00000000, 1'b1, 32'h40000000, 5'b00000},
            '{MUL, 32'h3F800000, 32'h40000000, 1'b0, 32'h00000000, 5'b00000},
            '{SUB, 32'h80000000, 32'h00000000, 1'b1, 32'h80000000, 5'b00000},
            '{MUL, 32'h7F800000, 32'hC0000000, 1'b1, 32'hFF800000, 5'b00000},
            '{DIV, 32'h3F800000, 32'h7F800000, 1'b1, 32'h00000000, 5'b00000},
            '{DIV, 32'hFF800000, 32'h00000000, 1'b1, 32'hFF800000, 5'b00000},
            '{ADD, 32'h7F800000, 32'h7F800000, 1'b1, 32'h7F800000, 5'b00000},
            '{DIV, 32'h80000000, 32'h3F800000, 1'b1, 32'h80000000, 5'b00000},
            '{ADD, 32'h3F800000, 32'hC0000000, 1'b0, 32'h00000000, 5'b00000},
            '{MUL, 32'h00000000, 32'h7FA00000, 1'b1, 32'h7FE00000, 5'b10000},
            '{SUB, 32'h00000000, 32'h40000000, 1'b1, 32'hC0000000, 5'b00000}
        };
        for (int i = 0; i < 17; i++) begin
            sendPair(v[i].a, v[i].b, v[i].mode, 1'b1, sp, r, f, lat);
            checks++;
            if (sp !== v[i].sp) begin
                failures++;
                $display("[TB] FAIL vec%0d_special got=%b want=%b", i, sp, v[i].sp);
            end
            checks++;
            if (r !== v[i].r) begin
                failures++;
                $display("[TB] FAIL vec%0d_result got=%h want=%h", i, r, v[i].r);
            end
            checks++;
            if (f !== v[i].f) begin
                failures++;
                $display("[TB] FAIL vec%0d_flags got=%b want=%b", i, f, v[i].f);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back();
        logic [31:0] pa [4];
        logic [31:0] pb [4];
        logic [1:0]  pm [4];
        logic [31:0] er [4];
        logic [4:0]  ef [4];
        logic [31:0] heldR;
        logic [4:0]  heldF;
        logic        hsIn;
        int          idx;
        int          got;
        pa = '{32'h7F800000, 32'h3F800000, 32'h40000000, 32'h00000000};
        pb = '{32'h00000000, 32'h80000000, 32'h00000000, 32'h40000000};
        pm = '{MUL, DIV, SUB, SUB};
        er = '{32'hFFC00000, 32'hFF800000, 32'h40000000, 32'hC0000000};
        ef = '{5'b10000, 5'b01000, 5'b00000, 5'b00000};
        idx   = 0;
        got   = 0;
        heldR = '0;
        heldF = '0;
        for (int cyc = 0; cyc < 40 && got < 4; cyc++) begin
            bus.in_valid = (idx < 4);
            if (idx < 4) begin
                bus.op_a    = pa[idx];
                bus.op_b    = pb[idx];
                bus.op_mode = pm[idx];
            end
            bus.out_ready = (cyc >= 5);
            @(negedge clk);
            if (cyc == 2) begin
                checks++;
                if (bus.in_ready !== 1'b0 || idx != 2) begin
                    failures++;
                    $display("[TB] FAIL b2b_backpressure got in_ready=%b accepted=%0d want in_ready=0 accepted=2",
                             bus.in_ready, idx);
                end
                heldR = bus.out_result;
                heldF = bus.out_flags;
            end
            if (cyc == 3 || cyc == 4) begin
                checks++;
                if (bus.out_valid !== 1'b1 || bus.out_result !== heldR || bus.out_flags !== heldF) begin
                    failures++;
                    $display("[TB] FAIL b2b_stall_hold got=%b/%h/%b want=1/%h/%b",
                             bus.out_valid, bus.out_result, bus.out_flags, heldR, heldF);
                end
            end
            hsIn = bus.in_valid & bus.in_ready;
            if (bus.out_valid && bus.out_ready) begin
                checks++;
                if (bus.out_result !== er[got] || bus.out_flags !== ef[got]) begin
                    failures++;
                    $display("[TB] FAIL b2b_order%0d got=%h/%b want=%h/%b",
                             got, bus.out_result, bus.out_flags, er[got], ef[got]);
                end
                got++;
            end
            @(posedge clk);
            #1;
            if (hsIn) idx++;
        end
        bus.in_valid = 1'b0;
        checks++;
        if (got != 4) begin
            failures++;
            $display("[TB] FAIL b2b_count got=%0d want=4", got);
        end
        @(posedge clk);
        #1;
        checks++;
        if (bus.out_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL b2b_no_duplicate got=%b want=0", bus.out_valid);
        end
    endtask

    task automatic test_sticky();
        logic        sp;
        logic [31:0] r;
        logic [4:0]  f;
        int          lat;
        bus.flags_clr = 1'b1;
        @(posedge clk);
        #1;
        bus.flags_clr = 1'b0;
        sendPair(32'h7F800000, 32'h7F800000, SUB, 1'b1, sp, r, f, lat);
        sendPair(32'h3F800000, 32'h80000000, DIV, 1'b1, sp, r, f, lat);
        @(posedge clk);
        #1;
        checks++;
        if (bus.sticky_flags !== 5'b11000) begin
            failures++;
            $display("[TB] FAIL sticky_accumulate got=%b want=11000", bus.sticky_flags);
        end
        sendPair(32'h7F800000, 32'h00000000, MUL, 1'b0, sp, r, f, lat);
        checks++;
        if (bus.sticky_flags !== 5'b11000) begin
            failures++;
            $display("[TB] FAIL sticky_no_update_while_stalled got=%b want=11000", bus.sticky_flags);
        end
        bus.flags_clr = 1'b1;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.flags_clr = 1'b0;
        checks++;
        if (bus.sticky_flags !== 5'b00000) begin
            failures++;
            $display("[TB] FAIL sticky_clear_priority got=%b want=00000", bus.sticky_flags);
        end
    endtask

    task automatic test_midreset();
        logic        sp;
        logic [31:0] r;
        logic [4:0]  f;
        int          lat;
        logic        stale;
        sendPair(32'h3F800000, 32'h00000000, DIV, 1'b1, sp, r, f, lat);
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.op_a      = 32'h7F800000;
        bus.op_b      = 32'h00000000;
        bus.op_mode   = MUL;
        @(posedge clk);
        #1;
        bus.op_mode = DIV;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b1 || bus.sticky_flags !== 5'b01000) begin
            failures++;
            $display("[TB] FAIL midreset_setup got=%b/%b want=1/01000", bus.out_valid, bus.sticky_flags);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.out_valid, bus.out_special, bus.out_result, bus.out_flags, bus.sticky_flags} !== 44'd0) begin
            failures++;
            $display("[TB] FAIL midreset_clear got=%b/%b/%h/%b/%b want=all zero", bus.out_valid,
                     bus.out_special, bus.out_result, bus.out_flags, bus.sticky_flags);
        end
        @(negedge clk);
        rst_n         = 1'b1;
        bus.out_ready = 1'b1;
        stale         = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (bus.out_valid) stale = 1'b1;
        end
        checks++;
        if (stale !== 1'b0) begin
            failures++;
            $display("[TB] FAIL midreset_stale_output got=%b want=0", stale);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.op_a      = '0;
        bus.op_b      = '0;
        bus.op_mode   = MUL;
        bus.out_ready = 1'b1;
        bus.flags_clr = 1'b0;
        #12;
        test_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        test_latency();
        test_special_cases();
        test_back_to_back();
        test_sticky();
        test_midreset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout got=running want=finished");
        $fatal(1, "[TB] timeout");
    end

endmodule

// File: doc/fp_special_resolver.md
Name: fp_special_resolver

Overview:
- Pipelined special-operand resolver for the FP arithmetic units; supports MUL, DIV, ADD and SUB.
- Classifies both operands internally and decides whether the IEEE-754 result is fully determined by special cases: NaN, Inf, zero, or an exact zero-addend passthrough.
- When it is, the block produces the packed result and the exception flags. Otherwise it tells the main datapath to compute the result.
- Sits beside the operand-unpack stage. It uses a valid/ready handshake and keeps sticky flags.

Parameters:
- IS_DOUBLE, 0, selects binary64 (1) or binary32 (0).
- EXP_WIDTH, IS_DOUBLE ? 11 : 8, exponent width.
- MANT_WIDTH, IS_DOUBLE ? 52 : 23, stored fraction width.
- TOTAL_WIDTH, EXP_WIDTH+MANT_WIDTH+1, packed operand width.
- CANON_NAN_SIGN, 1, sign bit of the default NaN generated on invalid operations.
- DAZ, 0, 1 = denormal inputs are treated as signed zero.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  block can accept a pair this cycle.
- op_a  in  TOTAL_WIDTH  first operand.
- op_b  in  TOTAL_WIDTH  second operand.
- op_mode  in  2  operation: 00 MUL, 01 DIV, 10 ADD, 11 SUB.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- out_special  out  1  1 = out_result is final; 0 = datapath must compute.
- out_result  out  TOTAL_WIDTH  special result; all zeros when out_special=0.
- out_flags  out  5  {NV, DZ, OF, UF, NX} for this result. OF, UF and NX are always 0.
- sticky_flags  out  5  OR of out_flags over all completed output handshakes.
- flags_clr  in  1  synchronous clear of sticky_flags.

Behaviour:
- Reset (rst_n=0, asynchronous): both pipeline valid bits are cleared. out_valid=0, out_special=0, out_result=0, out_flags=0, sticky_flags=0. Reset mid-operation discards in-flight pairs without producing output.
- Pipeline stage S1 registers the class vectors {nan, snan, inf, zero, finite}, signs, op_mode and both raw operands.
  - SUB inverts the sign of b before classification.
  - snan means exponent all ones, fraction non-zero, fraction MSB 0.
  - With DAZ=1, exponent 0 counts as zero.
- Pipeline stage S2 registers the result and flags. Latency is 2 cycles from the input handshake to out_valid while there is no stall.
- Handshake:
  - s2_load = !s2_v | out_ready.
  - s1_load = !s1_v | s2_load.
  - in_ready = s1_load.
  - One pair per cycle at full throughput. Order is preserved and there is no drop or duplication.
  - out_* are held stable while out_valid=1 and out_ready=0.
- Priority, first match wins:
  1. Either operand NaN: result is the NaN quieted (fraction MSB forced to 1). op_a's NaN is chosen if a is NaN, otherwise b's. NV=1 if either operand is snan.
  2. Invalid: MUL inf*0 or 0*inf; DIV 0/0 or inf/inf; ADD/SUB inf + (-inf). Result is {CANON_NAN_SIGN, exponent all ones, 1, zeros}. NV=1.
  3. MUL/DIV, sign = sa^sb:
     - MUL with either operand inf → inf.
     - DIV inf/x → inf.
     - DIV finite-nonzero/0 → inf with DZ=1.
     - MUL with either operand 0 → zero.
     - DIV 0/x → zero.
     - DIV x/inf → zero.
  4. ADD/SUB:
     - Either operand inf → that inf (the effective sign after the SUB flip).
     - Both zero → -0 if both effective signs are 1, else +0 (RNE only).
     - Exactly one zero → the other operand unchanged (sign-flipped b for SUB).
  5. Otherwise out_special=0, out_result=0, out_flags=0.
- sticky_flags update on a cycle where out_valid & out_ready: sticky_flags |= out_flags.
- flags_clr has priority over an update in the same cycle; the result is 0.

Decomposition:
- Package fp_pkg holds:
  - format constants derived from IS_DOUBLE;
  - op_mode encodings (FP_MUL, FP_DIV, FP_ADD, FP_SUB);
  - flag bit indices;
  - the class-vector struct.
- One sub-module, fp_classify, is natural: a combinational per-operand class decode with a DAZ parameter, instantiated twice in S1.

Test Plan:
- MUL, op_a=0x7F800000, op_b=0x00000000 → out_special=1, out_result=0xFFC00000, out_flags=5'b10000, out_valid exactly 2 cycles after the input handshake.
- MUL, op_a=0x7F800001 (sNaN), op_b=0x3F800000 → out_result=0x7FC00001, NV=1. With op_a=0x3F800000, op_b=0xFFC00005 → out_result=0xFFC00005, NV=0.
- DIV, 0x3F800000 / 0x80000000 → out_result=0xFF800000, DZ=1. DIV, 0x00000000 / 0x00000000 → 0xFFC00000, NV=1.
- SUB, 0x7F800000 - 0x7F800000 → 0xFFC00000, NV=1. ADD, 0x80000000 + 0x00000000 → 0x00000000. SUB, 0x40000000 - 0x00000000 → 0x40000000, special=1. MUL, 0x3F800000 * 0x40000000 → out_special=0, result 0.
- Back-to-back stream of 4 pairs with out_ready=0 for 3 cycles → in_ready drops after 2 accepted pairs. Outputs stay stable while stalled, then appear in order with no loss.
- Sticky flags:
  - NV then DZ results → sticky_flags=5'b11000.
  - flags_clr asserted in the same cycle as an NV handshake → sticky_flags=0.
  - rst_n low while 2 pairs are in flight → out_valid=0 immediately, and no stale output after release.
